// File: rtl/pipeline_ctrl.sv
// Hazard/mul-div stall controller: load-use bubbles, taken-branch flush, multi-cycle mul/div handshake (PIPE_CTRL_MD_TIMEOUT_EN adds an MD_BUSY abort counter).
// Latency: stall/bubble/flush/md_start are combinational from inputs; md_we/md_exc appear one cycle after md_ready (or the timeout pulse).
// Backpressure: stall holds PC and F/D for the whole mul/div, upstream waits indefinitely unless the timeout build is selected.
module pipeline_ctrl #(
    parameter int MD_TIMEOUT = 40
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic       d_uses_rt,
    input  logic       x_is_load,
    input  logic [4:0] x_rd,
    input  logic       x_md_valid,
    input  logic       x_branch_taken,
    input  logic       md_ready,
    input  logic       md_exception,
    output logic       stall,
    output logic       bubble,
    output logic       flush,
    output logic       md_start,
    output logic       md_we,
    output logic       md_exc,
    output logic       md_timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   exc_q, exc_d;
    logic   load_use;
    logic   to_hit;

    if (MD_TIMEOUT < 1) begin : g_bad_timeout
        $error("pipeline_ctrl: MD_TIMEOUT must be at least 1");
    end

    // r0 is hardwired zero, so a load targeting it never creates a dependency.
    assign load_use = x_is_load && (x_rd != 5'd0) &&
                      ((x_rd == d_rs) || (d_uses_rt && (x_rd == d_rt)));

`ifdef PIPE_CTRL_MD_TIMEOUT_EN
    localparam int CW = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign to_hit = (cnt_q == CW'(MD_TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == IDLE) && (state_d == MD_BUSY)) begin
            cnt_d = '0;
        end else if (state_q == MD_BUSY) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        exc_d      = exc_q;
        stall      = 1'b0;
        bubble     = 1'b0;
        flush      = 1'b0;
        md_start   = 1'b0;
        md_we      = 1'b0;
        md_exc     = 1'b0;
        md_timeout = 1'b0;

        case (state_q)
            IDLE: begin
                // Mul/div wins over a coincident taken branch; flush wins over load-use.
                if (x_md_valid) begin
                    md_start = 1'b1;
                    stall    = 1'b1;
                    exc_d    = 1'b0;
                    state_d  = MD_BUSY;
                end else if (x_branch_taken) begin
                    flush  = 1'b1;
                    bubble = 1'b1;
                end else if (load_use) begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                end
            end
            MD_BUSY: begin
                stall  = 1'b1;
                bubble = 1'b1;
                if (md_ready) begin
                    exc_d   = md_exception;
                    state_d = MD_DONE;
                end else if (to_hit) begin
                    md_timeout = 1'b1;
                    exc_d      = 1'b1;
                    state_d    = MD_DONE;
                end
            end
            MD_DONE: begin
                md_we   = 1'b1;
                md_exc  = exc_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs must read zero for the whole time reset is held, not just after the next edge.
        if (!reset) begin
            stall      = 1'b0;
            bubble     = 1'b0;
            flush      = 1'b0;
            md_start   = 1'b0;
            md_we      = 1'b0;
            md_exc     = 1'b0;
            md_timeout = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            exc_q   <= exc_d;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed hazard/mul-div scenarios followed by randomized traffic against a cycle-level reference model.
module tb_pipeline_ctrl;

    localparam int MD_TIMEOUT = 40;
`ifdef PIPE_CTRL_MD_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] d_rs, d_rt, x_rd;
    logic       d_uses_rt, x_is_load, x_md_valid, x_branch_taken;
    logic       md_ready, md_exception;
    logic       stall, bubble, flush, md_start, md_we, md_exc, md_timeout;

    int checks   = 0;
    int failures = 0;

    // Reference model: is an op outstanding, how many busy cycles it has used, is a result due.
    bit m_op;
    int m_busy_n;
    bit m_due;
    bit m_exc;

    bit e_stall, e_bubble, e_flush, e_start, e_we, e_exc, e_to;
    logic o_stall, o_bubble, o_flush, o_start, o_we, o_exc, o_to;

    int n_stall, n_start, n_we, n_to;

    pipeline_ctrl #(.MD_TIMEOUT(MD_TIMEOUT)) dut (
        .clock          (clock),
        .reset          (reset),
        .d_rs           (d_rs),
        .d_rt           (d_rt),
        .d_uses_rt      (d_uses_rt),
        .x_is_load      (x_is_load),
        .x_rd           (x_rd),
        .x_md_valid     (x_md_valid),
        .x_branch_taken (x_branch_taken),
        .md_ready       (md_ready),
        .md_exception   (md_exception),
        .stall          (stall),
        .bubble         (bubble),
        .flush          (flush),
        .md_start       (md_start),
        .md_we          (md_we),
        .md_exc         (md_exc),
        .md_timeout     (md_timeout)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        d_rs = 5'd0; d_rt = 5'd0; d_uses_rt = 1'b0;
        x_is_load = 1'b0; x_rd = 5'd0; x_md_valid = 1'b0;
        x_branch_taken = 1'b0; md_ready = 1'b0; md_exception = 1'b0;
    endtask

    task automatic expect_outputs();
        bit lu;
        {e_stall, e_bubble, e_flush, e_start, e_we, e_exc, e_to} = '0;
        lu = x_is_load && (x_rd != 0) && ((x_rd == d_rs) || (d_uses_rt && (x_rd == d_rt)));
        if (reset !== 1'b1) begin
            // everything low
        end else if (m_due) begin
            e_we  = 1'b1;
            e_exc = m_exc;
        end else if (m_op) begin
            e_stall  = 1'b1;
            e_bubble = 1'b1;
            e_to     = TO_EN && (m_busy_n == MD_TIMEOUT - 1) && !md_ready;
        end else if (x_md_valid) begin
            e_start = 1'b1;
            e_stall = 1'b1;
        end else if (x_branch_taken) begin
            e_flush  = 1'b1;
            e_bubble = 1'b1;
        end else if (lu) begin
            e_stall  = 1'b1;
            e_bubble = 1'b1;
        end
    endtask

    task automatic model_edge();
        if (reset !== 1'b1) begin
            m_op = 1'b0; m_busy_n = 0; m_due = 1'b0; m_exc = 1'b0;
        end else if (m_due) begin
            m_due = 1'b0;
        end else if (m_op) begin
            if (md_ready) begin
                m_exc = md_exception; m_due = 1'b1; m_op = 1'b0;
            end else if (TO_EN && (m_busy_n == MD_TIMEOUT - 1)) begin
                m_exc = 1'b1; m_due = 1'b1; m_op = 1'b0;
            end else begin
                m_busy_n++;
            end
        end else if (x_md_valid) begin
            m_op = 1'b1; m_busy_n = 0;
        end
    endtask

    // Called at a falling edge with inputs already applied; checks, then advances one cycle.
    task automatic step(input string tag);
        #1;
        expect_outputs();
        o_stall = stall; o_bubble = bubble; o_flush = flush; o_start = md_start;
        o_we = md_we; o_exc = md_exc; o_to = md_timeout;
        chk({tag, ".stall"},      o_stall,  e_stall);
        chk({tag, ".bubble"},     o_bubble, e_bubble);
        chk({tag, ".flush"},      o_flush,  e_flush);
        chk({tag, ".md_start"},   o_start,  e_start);
        chk({tag, ".md_we"},      o_we,     e_we);
        chk({tag, ".md_exc"},     o_exc,    e_exc);
        chk({tag, ".md_timeout"}, o_to,     e_to);
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    task automatic clear_counts();
        n_stall = 0; n_start = 0; n_we = 0; n_to = 0;
    endtask

    task automatic count_obs();
        n_stall += int'(o_stall);
        n_start += int'(o_start);
        n_we    += int'(o_we);
        n_to    += int'(o_to);
    endtask

    initial begin
        m_op = 1'b0; m_busy_n = 0; m_due = 1'b0; m_exc = 1'b0;
        reset = 1'b0;
        idle_inputs();
        x_md_valid = 1'b1; x_branch_taken = 1'b1; x_is_load = 1'b1;
        x_rd = 5'd3; d_rs = 5'd3; md_ready = 1'b1;
        @(negedge clock);
        step("reset_a");
        chk("reset_stall_low", o_stall, 1'b0);
        step("reset_b");

        // Load-use on rs, then with x_rd = r0
        idle_inputs();
        reset = 1'b1;
        step("idle");
        x_is_load = 1'b1; x_rd = 5'd5; d_rs = 5'd5;
        step("lu_rs");
        chk("lu_rs_stall", o_stall, 1'b1);
        chk("lu_rs_bubble", o_bubble, 1'b1);
        x_rd = 5'd0; d_rs = 5'd0;
        step("lu_r0");
        chk("lu_r0_stall", o_stall, 1'b0);
        x_rd = 5'd9; d_rs = 5'd1; d_rt = 5'd9; d_uses_rt = 1'b0;
        step("lu_rt_unused");
        d_uses_rt = 1'b1;
        step("lu_rt_used");
        x_is_load = 1'b0;
        step("lu_not_load");

        // Mul/div answering in the 17th busy cycle
        idle_inputs();
        clear_counts();
        x_md_valid = 1'b1;
        step("md17_start");
        count_obs();
        x_md_valid = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            md_ready = (i == 17);
            step("md17_busy");
            count_obs();
        end
        md_ready = 1'b0;
        step("md17_done");
        chk("md17_done_stall", o_stall, 1'b0);
        chk("md17_done_we", o_we, 1'b1);
        count_obs();
        step("md17_after");
        count_obs();
        chk_int("md17_start_cycles", n_start, 1);
        chk_int("md17_stall_cycles", n_stall, 18);
        chk_int("md17_we_cycles", n_we, 1);

        // Branch priority
        x_branch_taken = 1'b1; x_is_load = 1'b1; x_rd = 5'd7; d_rs = 5'd7;
        step("br_lu");
        chk("br_lu_flush", o_flush, 1'b1);
        chk("br_lu_stall", o_stall, 1'b0);
        x_md_valid = 1'b1;
        step("br_md");
        chk("br_md_flush", o_flush, 1'b0);
        chk("br_md_start", o_start, 1'b1);
        idle_inputs();
        x_branch_taken = 1'b1;
        md_ready = 1'b1;
        step("br_ignored_busy");
        step("br_ignored_done");
        idle_inputs();

        // Reset in the 5th busy cycle
        x_md_valid = 1'b1;
        step("rmid_start");
        x_md_valid = 1'b0;
        for (int i = 1; i <= 4; i++) step("rmid_busy");
        reset = 1'b0;
        x_branch_taken = 1'b1; x_md_valid = 1'b1;
        step("rmid_reset");
        chk("rmid_stall_zero", o_stall, 1'b0);
        chk("rmid_bubble_zero", o_bubble, 1'b0);
        idle_inputs();
        reset = 1'b1;
        step("rmid_idle");
        chk("rmid_idle_stall", o_stall, 1'b0);
        x_md_valid = 1'b1;
        step("rmid_resample");
        chk("rmid_resample_start", o_start, 1'b1);
        x_md_valid = 1'b0;
        md_ready = 1'b1;
        step("rmid_ready");
        md_ready = 1'b0;
        step("rmid_done");

        // md_ready never arrives
        clear_counts();
        x_md_valid = 1'b1;
        step("slow_start");
        x_md_valid = 1'b0;
`ifdef PIPE_CTRL_MD_TIMEOUT_EN
        for (int i = 1; i <= MD_TIMEOUT; i++) begin
            step("slow_busy");
            count_obs();
        end
        chk("slow_to_last_busy", o_to, 1'b1);
        chk_int("slow_to_pulses", n_to, 1);
        step("slow_to_done");
        chk("slow_to_done_we", o_we, 1'b1);
        chk("slow_to_done_exc", o_exc, 1'b1);
`else
        for (int i = 1; i <= 100; i++) begin
            step("slow_busy");
            count_obs();
        end
        chk("slow_stall_at_100", o_stall, 1'b1);
        chk_int("slow_to_pulses", n_to, 0);
        md_ready = 1'b1;
        step("slow_ready");
        md_ready = 1'b0;
        step("slow_done");
        chk("slow_done_we", o_we, 1'b1);
`endif
        step("slow_after");

        // Exception latched only for the MD_DONE cycle
        x_md_valid = 1'b1;
        step("exc_start");
        x_md_valid = 1'b0;
        md_ready = 1'b1; md_exception = 1'b1;
        step("exc_ready");
        md_ready = 1'b0; md_exception = 1'b0;
        step("exc_done");
        chk("exc_done_exc", o_exc, 1'b1);
        step("exc_after");
        chk("exc_after_exc", o_exc, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(0, 99) != 0);
            d_rs           = 5'($urandom_range(0, 3));
            d_rt           = 5'($urandom_range(0, 3));
            x_rd           = 5'($urandom_range(0, 3));
            d_uses_rt      = 1'($urandom_range(0, 1));
            x_is_load      = 1'($urandom_range(0, 1));
            x_md_valid     = ($urandom_range(0, 9) == 0);
            x_branch_taken = ($urandom_range(0, 4) == 0);
            md_ready       = ($urandom_range(0, 5) == 0);
            md_exception   = 1'($urandom_range(0, 1));
            step("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
